// File: rtl/serial_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package serial_pkg;

  localparam int unsigned MAX_DATA_W = 9;
  localparam int unsigned IDX_W      = $clog2(MAX_DATA_W + 1);

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  // Parity bit for a zero-extended data word; zero padding does not alter the XOR.
  function automatic logic calc_parity(input parity_e mode, input logic [MAX_DATA_W-1:0] data);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: bit_done is high in the last sr_clk cycle of each bit.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic sr_clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done,
  output logic pre_done_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  // done_q mirrors (cnt_q == LAST) but comes straight from a flop.
  always_ff @(posedge sr_clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= (CLKS_PER_BIT == 1);
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == LAST);
    end
  end

  assign bit_done   = done_q;
  // High when the following cycle will be the last of the bit (no clear pending).
  assign pre_done_c = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt_q == PRE_LAST);

endmodule

// File: rtl/serial_tx_frame.sv
// Framed LSB-first serial transmitter with valid/ready input and gapless frames.
// Optional SERIAL_TX_BREAK_EN adds tx_break to hold the idle line low.
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter parity_e     PARITY       = PAR_NONE,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              sr_clk,
  input  logic              reset,
`ifdef SERIAL_TX_BREAK_EN
  input  logic              tx_break,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              data_out_q, data_out_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              brk, hs, clear, bit_done, pre_done_c, last_stop_next;

`ifdef SERIAL_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  // in_ready_q is only ever high in IDLE or the final stop cycle.
  assign hs = in_valid & in_ready_q;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .sr_clk    (sr_clk),
    .reset     (reset),
    .clear     (clear),
    .bit_done  (bit_done),
    .pre_done_c(pre_done_c)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    clear      = 1'b0;
    data_out_d = 1'b1;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: ;
      START: if (bit_done) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_done) begin
        shreg_d = shreg_q >> 1;
        if (idx_q == LAST_DATA) begin
          state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      PAR: if (bit_done) begin
        state_d = STOP;
        idx_d   = '0;
      end
      STOP: if (bit_done) begin
        if (idx_q == LAST_STOP) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepting a word overrides the end-of-frame return to IDLE.
    if (hs) begin
      state_d = START;
      idx_d   = '0;
      shreg_d = in_data;
      par_d   = calc_parity(PARITY, MAX_DATA_W'(in_data));
      clear   = 1'b1;
    end

    // Look ahead: will the next cycle be the final cycle of the last stop bit?
    if (CLKS_PER_BIT == 1) last_stop_next = (state_d == STOP) && (idx_d == LAST_STOP);
    else                   last_stop_next = (state_q == STOP) && (idx_q == LAST_STOP) && pre_done_c;

    case (state_d)
      IDLE:    data_out_d = ~brk;
      START:   data_out_d = 1'b0;
      DATA:    data_out_d = shreg_d[0];
      PAR:     data_out_d = par_d;
      default: data_out_d = 1'b1;
    endcase
    in_ready_d = ~brk & ((state_d == IDLE) | last_stop_next);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge sr_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      data_out_q <= 1'b1;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: four configurations checked against a frame-level model.
`timescale 1ns/1ps
module tb_serial_tx_frame;
  import serial_pkg::*;

  logic            sr_clk = 1'b0;
  logic            rst_n  = 1'b1;
  logic [3:0]      valid  = '0;
  logic [3:0]      brk    = '0;
  logic [3:0][8:0] din    = '0;
  logic [3:0]      dout, bsy, rdy;
  int              checks = 0;
  int              errors = 0;

  always #5 sr_clk = ~sr_clk;

  serial_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY(PAR_EVEN), .CLKS_PER_BIT(4)) u_even (
    .sr_clk(sr_clk), .reset(rst_n),
`ifdef SERIAL_TX_BREAK_EN
    .tx_break(brk[0]),
`endif
    .in_data(din[0][7:0]), .in_valid(valid[0]), .in_ready(rdy[0]), .data_out(dout[0]), .busy(bsy[0]));

  serial_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY(PAR_ODD), .CLKS_PER_BIT(4)) u_odd (
    .sr_clk(sr_clk), .reset(rst_n),
`ifdef SERIAL_TX_BREAK_EN
    .tx_break(brk[1]),
`endif
    .in_data(din[1][7:0]), .in_valid(valid[1]), .in_ready(rdy[1]), .data_out(dout[1]), .busy(bsy[1]));

  serial_tx_frame #(.DATA_W(8), .STOP_BITS(2), .PARITY(PAR_NONE), .CLKS_PER_BIT(1)) u_fast (
    .sr_clk(sr_clk), .reset(rst_n),
`ifdef SERIAL_TX_BREAK_EN
    .tx_break(brk[2]),
`endif
    .in_data(din[2][7:0]), .in_valid(valid[2]), .in_ready(rdy[2]), .data_out(dout[2]), .busy(bsy[2]));

  serial_tx_frame #(.DATA_W(5), .STOP_BITS(1), .PARITY(PAR_NONE), .CLKS_PER_BIT(16)) u_narrow (
    .sr_clk(sr_clk), .reset(rst_n),
`ifdef SERIAL_TX_BREAK_EN
    .tx_break(brk[3]),
`endif
    .in_data(din[3][4:0]), .in_valid(valid[3]), .in_ready(rdy[3]), .data_out(dout[3]), .busy(bsy[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int cfg_dw(input int id);   return (id == 3) ? 5 : 8; endfunction
  function automatic int cfg_stop(input int id); return (id == 2) ? 2 : 1; endfunction
  function automatic int cfg_par(input int id);  return (id == 0) ? 1 : (id == 1) ? 2 : 0; endfunction
  function automatic int cfg_cpb(input int id);  return (id <= 1) ? 4 : (id == 2) ? 1 : 16; endfunction

  // Model: one queue entry per expected sr_clk cycle of a frame.
  typedef struct packed {
    logic dout;
    logic last;
  } exp_t;

  exp_t       mq [4][$];
  logic [3:0] brk_st = '0;

  task automatic push_frame(input int id, input logic [8:0] d);
    logic bits[$];
    int   ones;
    exp_t e;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_dw(id); i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_par(id) == 1) bits.push_back((ones % 2) == 1);
    else if (cfg_par(id) == 2) bits.push_back((ones % 2) == 0);
    for (int i = 0; i < cfg_stop(id); i++) bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      for (int c = 0; c < cfg_cpb(id); c++) begin
        e.dout = bits[j];
        e.last = (j == bits.size() - 1) && (c == cfg_cpb(id) - 1);
        mq[id].push_back(e);
      end
    end
  endtask

  always @(posedge sr_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int id = 0; id < 4; id++) mq[id].delete();
      brk_st = '0;
    end else begin
      for (int id = 0; id < 4; id++) begin
        logic cur_rdy;
        cur_rdy = (mq[id].size() != 0) ? (mq[id][0].last & ~brk_st[id]) : ~brk_st[id];
        if (mq[id].size() != 0) void'(mq[id].pop_front());
        if (valid[id] && cur_rdy) push_frame(id, din[id]);
        brk_st[id] = brk[id];
      end
    end
  end

  always @(negedge sr_clk) begin
    for (int id = 0; id < 4; id++) begin
      logic [2:0] ev;
      if (mq[id].size() != 0) ev = {mq[id][0].dout, 1'b1, mq[id][0].last & ~brk_st[id]};
      else                    ev = {~brk_st[id], 1'b0, ~brk_st[id]};
      chk($sformatf("model%0d", id), 32'({dout[id], bsy[id], rdy[id]}), 32'(ev));
    end
  end

  logic cap [0:127];
  int   busy_n, rdy_n, rdy_at;

  task automatic send(input int id, input logic [8:0] d);
    din[id]   = d;
    valid[id] = 1'b1;
    @(negedge sr_clk);
    valid[id] = 1'b0;
  endtask

  task automatic capture(input int id, input int n, input int poke_at,
                         input logic [8:0] poke_din, input logic poke_valid);
    busy_n = 0;
    rdy_n  = 0;
    rdy_at = -1;
    for (int k = 0; k < n; k++) begin
      cap[k] = dout[id];
      if (bsy[id]) busy_n++;
      if (rdy[id]) begin
        rdy_n++;
        rdy_at = k;
      end
      if (k == poke_at) begin
        din[id]   = poke_din;
        valid[id] = poke_valid;
      end
      @(negedge sr_clk);
    end
  endtask

  logic [10:0] e11;
  logic [21:0] e22;
  logic [6:0]  e7;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sr_clk);
    for (int id = 0; id < 4; id++)
      chk($sformatf("reset_idle%0d", id), 32'({dout[id], bsy[id], rdy[id]}), 32'(3'b101));
    rst_n = 1'b1;
    repeat (2) @(negedge sr_clk);

    // Even parity, 0x43
    send(0, 9'h043);
    capture(0, 44, -1, 9'h0, 1'b0);
    e11 = 11'b11010000110;
    for (int k = 0; k < 44; k++) chk($sformatf("t1_line%0d", k), 32'(cap[k]), 32'(e11[k / 4]));
    chk("t1_busy_cycles", busy_n, 44);
    chk("t1_ready_count", rdy_n, 1);
    chk("t1_ready_at", rdy_at, 43);
    chk("t1_idle_after", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b101));

    // Odd parity, 0x99
    send(1, 9'h099);
    capture(1, 44, -1, 9'h0, 1'b0);
    e11 = 11'b11100110010;
    for (int k = 0; k < 44; k++) chk($sformatf("t2_line%0d", k), 32'(cap[k]), 32'(e11[k / 4]));
    chk("t2_idle_after", 32'({dout[1], bsy[1], rdy[1]}), 32'(3'b101));

    // Gapless back-to-back frames at one clock per bit
    din[2]   = 9'h0A5;
    valid[2] = 1'b1;
    @(negedge sr_clk);
    din[2] = 9'h03C;
    capture(2, 22, 11, 9'h03C, 1'b0);
    e22 = 22'b1100111100011101001010;
    for (int k = 0; k < 22; k++) chk($sformatf("t3_line%0d", k), 32'(cap[k]), 32'(e22[k]));
    chk("t3_busy_cycles", busy_n, 22);
    chk("t3_ready_count", rdy_n, 2);
    chk("t3_idle_after", 32'({dout[2], bsy[2], rdy[2]}), 32'(3'b101));

    // Asynchronous reset in the fifth data bit
    send(0, 9'h000);
    repeat (21) @(negedge sr_clk);
    chk("t4_pre_reset", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b010));
    #1 rst_n = 1'b0;
    #1 chk("t4_async_reset", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b101));
    @(negedge sr_clk);
    rst_n = 1'b1;
    @(negedge sr_clk);
    send(0, 9'h001);
    capture(0, 44, -1, 9'h0, 1'b0);
    e11 = 11'b11000000010;
    for (int k = 0; k < 44; k++) chk($sformatf("t4_line%0d", k), 32'(cap[k]), 32'(e11[k / 4]));
    chk("t4_busy_cycles", busy_n, 44);

    // Narrow word, slow bits, in_data disturbed mid-frame
    send(3, 9'h01F);
    capture(3, 112, 30, 9'h000, 1'b0);
    e7 = 7'b1111110;
    for (int k = 0; k < 112; k++) chk($sformatf("t5_line%0d", k), 32'(cap[k]), 32'(e7[k / 16]));
    chk("t5_busy_cycles", busy_n, 112);
    chk("t5_ready_count", rdy_n, 1);
    chk("t5_ready_at", rdy_at, 111);
    chk("t5_idle_after", 32'({dout[3], bsy[3], rdy[3]}), 32'(3'b101));

`ifdef SERIAL_TX_BREAK_EN
    // Break raised mid-frame: frame completes, then the line is held low
    send(0, 9'h043);
    repeat (9) @(negedge sr_clk);
    brk[0]   = 1'b1;
    valid[0] = 1'b1;
    din[0]   = 9'h055;
    capture(0, 35, -1, 9'h055, 1'b1);
    e11 = 11'b11010000110;
    for (int k = 0; k < 35; k++) chk($sformatf("t6_line%0d", k), 32'(cap[k]), 32'(e11[(k + 9) / 4]));
    chk("t6_busy_cycles", busy_n, 35);
    chk("t6_no_gapless", rdy_n, 0);
    chk("t6_break_line", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b000));
    repeat (3) @(negedge sr_clk);
    chk("t6_break_hold", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b000));
    valid[0] = 1'b0;
    brk[0]   = 1'b0;
    @(negedge sr_clk);
    chk("t6_break_release", 32'({dout[0], bsy[0], rdy[0]}), 32'(3'b101));
`endif

    repeat (2) @(negedge sr_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
Parametrised successor to the team's 8-bit PISO serial shifter. Serialises one word per frame, LSB first, onto an idle-high line: start bit, DATA_W data bits, optional parity bit, then 1 or 2 stop bits. It has an internal bit-period counter, so the line runs at sr_clk/CLKS_PER_BIT. A valid/ready handshake on the parallel side allows gapless back-to-back frames. It sits between the command/data FSM and the board serial pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
CLKS_PER_BIT, 16, sr_clk cycles per serial bit; must be >= 1.

Ports:
sr_clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
in_data  input  DATA_W  word to send; sampled only on a handshake.
in_valid  input  1  producer has a word.
in_ready  output  1  block accepts a word this cycle; handshake = in_valid & in_ready at the rising edge.
data_out  output  1  serial line; idle high.
busy  output  1  high whenever a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data_out=1, busy=0, in_ready=1, all counters 0. The outputs take these values immediately, without waiting for a clock edge. This applies mid-frame too: the frame is aborted and the line returns high.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: data_out=1, in_ready=1. On a handshake, latch in_data into the shift register, compute the parity bit, and go to START.
- START: data_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: data_out = shift register bit 0. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_W bits, go to PAR if PARITY!=0, else go to STOP.
- PAR: data_out = parity bit for CLKS_PER_BIT cycles.
  - Even mode: parity bit = XOR of the data bits.
  - Odd mode: parity bit = inverted XOR of the data bits.
  - Computed once, at handshake.
- STOP: data_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- in_ready is also high in the final sr_clk cycle of the last stop bit.
  - Handshake in that cycle: go directly to START, with no idle cycle (gapless).
  - No handshake: go to IDLE.
  - in_ready is 0 in every other non-IDLE cycle.
- Latency: the first start-bit cycle is the cycle after the handshake edge.
- Bit counter: clog2(CLKS_PER_BIT) bits wide; counts 0..CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1, every cycle is a bit boundary.
- Index counter: counts data bits 0..DATA_W-1 and stop bits 0..STOP_BITS-1.
- in_data changes while no handshake is pending have no effect. in_valid dropping mid-frame has no effect.
- data_out is registered, so it is glitch-free.
- busy = (state != IDLE).

Optional Feature:
Macro: SERIAL_TX_BREAK_EN.
- Defined: adds input port tx_break (1 bit).
  - In IDLE with tx_break=1: data_out=0, in_ready=0, state stays IDLE. A handshake is blocked.
  - A frame in progress completes normally. Break takes effect on return to IDLE, and suppresses the gapless accept in the last stop cycle.
  - When tx_break=0, normal idle resumes the next cycle.
- Undefined: no tx_break port; behaviour exactly as above.

Decomposition:
- Package serial_pkg:
  - parity_e enum: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2. Used for the PARITY parameter.
  - tx_state_e enum: IDLE, START, DATA, PAR, STOP.
  - localparam MAX_DATA_W=9.
- Sub-module baud_counter: parameter CLKS_PER_BIT; inputs sr_clk, reset, clear; output bit_done pulsing in the last cycle of each bit period. The FSM asserts clear on a handshake.

Test Plan:
1. DATA_W=8, PARITY=1, CLKS_PER_BIT=4, STOP_BITS=1. Send 8'h43 → data_out sequence 0,1,1,0,0,0,0,1,0,1(par),1(stop), each held 4 cycles (44 cycles total); busy high for exactly 44 cycles; in_ready high only in cycle 44.
2. Same config, PARITY=2, send 8'h99 → data bits 1,0,0,1,1,0,0,1; parity bit 1; line then returns high and in_ready=1.
3. PARITY=0, STOP_BITS=2, CLKS_PER_BIT=1. Hold in_valid=1 with 8'hA5 then 8'h3C → two back-to-back 11-cycle frames; start bit of frame 2 immediately follows the second stop bit (no idle cycle).
4. Drop reset to 0 in the 5th data bit of a frame → data_out=1, busy=0, in_ready=1 before the next sr_clk edge. After release, a new 8'h01 frame is transmitted correctly.
5. CLKS_PER_BIT=16, DATA_W=5, send 5'h1F, with in_data changed mid-frame → frame carries 1,1,1,1,1 unaffected; total (1+5+1)*16 = 112 cycles with PARITY=0.
6. (SERIAL_TX_BREAK_EN) Assert tx_break mid-frame → frame completes; then data_out=0 and in_ready=0 while asserted; deassert → data_out=1 and in_ready=1 next cycle.
